// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small first-in first-out byte queue
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 1042,
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [DATA_WIDTH-1:0]         i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int IW = $clog2(DATA_WIDTH + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic                  push, pop, bit_end, last_bit;
  assign o_ready  = count_q < (AW+1)'(FIFO_DEPTH);
  assign o_count  = count_q;
  assign o_tx     = tx_q;
  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign push     = i_valid && o_ready;
  assign bit_end  = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign last_bit = idx_q == IW'(DATA_WIDTH - 1);
  assign pop      = (state_q == IDLE || (state_q == STOP && bit_end)) && count_q != '0;
  // Next-state: frame sequencing, bit timing, queue bookkeeping; line outputs lag the state by one register
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = pop ? START : IDLE;
      START:   state_d = bit_end ? DATA : START;
      DATA:    state_d = (bit_end && last_bit) ? STOP : DATA;
      default: state_d = bit_end ? (pop ? START : IDLE) : STOP;
    endcase
    cnt_d    = (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;
    idx_d    = state_q != DATA ? '0 : bit_end ? (last_bit ? '0 : idx_q + 1'b1) : idx_q;
    shift_d  = pop ? mem_q[rd_ptr_q] : (state_q == DATA && bit_end) ? shift_q >> 1 : shift_q;
    tx_d     = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
    busy_d   = state_q != IDLE;
    done_d   = state_q == STOP && bit_end;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
  end
  // Control registers; reset forces an idle line and an empty queue at once
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  // Queue storage needs no reset: entries are only read after being written
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_data;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench with a UART receive model for uart_tx_fifo
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  localparam int CPB = 4;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] data = '0;
  logic valid = 1'b0;
  logic ready, tx, busy, done;
  logic [2:0] count;
  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  bit mon_en = 1'b1;
  logic [7:0] sb [$];
  time frame_t [$];
  logic [7:0] full_d [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic       full_r [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [2:0] full_c [6] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
  logic [2:0] trio_c [3] = '{3'd1, 3'd1, 3'd2};

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid),
    .o_ready(ready), .o_tx(tx), .o_busy(busy), .o_done(done), .o_count(count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (3) @(negedge clk);
    while ((busy || count != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", n < 2000, 1);
    repeat (2) @(negedge clk);
  endtask

  // receive model: every line level is sampled once per cycle and must hold for a full bit
  initial begin
    logic [9:0] line;
    logic v;
    bit bad;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && tx === 1'b0) begin
        frame_t.push_back($time);
        bad = 1'b0;
        for (int j = 0; j < 10; j++)
          for (int s = 0; s < CPB; s++) begin
            if (j != 0 || s != 0) @(negedge clk);
            v = tx;
            if (s == 0) line[j] = v;
            else if (v !== line[j]) bad = 1'b1;
            if (j == 0 && s == 1) check("busy_frame", busy, 1);
            if (j == 9 && s == CPB - 2) check("done_early", done, 0);
            if (j == 9 && s == CPB - 1) check("done_end", done, 1);
          end
        check("bit_width", bad, 0);
        check("start_bit", line[0], 0);
        check("stop_bit", line[9], 1);
        check("frame_expected", sb.size() != 0, 1);
        if (sb.size() != 0) check("rx_data", line[8:1], sb.pop_front());
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [7:0] r;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    check("rst_ready", ready, 1);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      repeat (5) @(negedge clk);
      check("idle_tx", tx, 1);
    end
    // single frame 0xA5
    d0 = done_cnt;
    check("a5_ready", ready, 1);
    data = 8'hA5; valid = 1'b1; sb.push_back(8'hA5);
    @(negedge clk); valid = 1'b0;
    check("a5_tx_e0", tx, 1);
    check("a5_cnt_e0", count, 1);
    @(negedge clk);
    check("a5_tx_e1", tx, 1);
    check("a5_cnt_e1", count, 0);
    @(negedge clk);
    check("a5_tx_e2", tx, 0);
    wait_idle();
    check("a5_done_cnt", done_cnt - d0, 1);
    // three back-to-back frames
    d0 = done_cnt;
    frame_t.delete();
    for (int i = 0; i < 3; i++) begin
      data = 8'(i + 1); valid = 1'b1; sb.push_back(8'(i + 1));
      @(negedge clk);
      check("b2b_cnt", count, trio_c[i]);
    end
    valid = 1'b0;
    wait_idle();
    check("b2b_frames", frame_t.size(), 3);
    for (int i = 1; i < frame_t.size(); i++)
      check("b2b_gap", 32'((frame_t[i] - frame_t[i-1]) / 10), 10 * CPB);
    check("b2b_done", done_cnt - d0, 3);
    // overfill: the sixth byte meets a full queue and is dropped
    for (int i = 0; i < 6; i++) begin
      check("full_ready", ready, full_r[i]);
      data = full_d[i]; valid = 1'b1;
      if (full_r[i]) sb.push_back(full_d[i]);
      @(negedge clk);
      check("full_cnt", count, full_c[i]);
    end
    valid = 1'b0;
    check("full_ready_low", ready, 0);
    wait_idle();
    // push coinciding with the back-to-back pop at count 2
    for (int i = 0; i < 3; i++) begin
      data = 8'h0A + 8'(i); valid = 1'b1; sb.push_back(8'h0A + 8'(i));
      @(negedge clk);
      check("pp_fill_cnt", count, trio_c[i]);
    end
    valid = 1'b0;
    repeat (10 * CPB - 2) @(negedge clk);
    check("pp_cnt_before", count, 2);
    check("pp_ready", ready, 1);
    data = 8'h0D; valid = 1'b1; sb.push_back(8'h0D);
    @(negedge clk); valid = 1'b0;
    check("pp_cnt_after", count, 2);
    wait_idle();
    // reset in the middle of data bit 3
    mon_en = 1'b0;
    data = 8'h3C; valid = 1'b1;
    @(negedge clk); valid = 1'b0;
    repeat (2) @(negedge clk);
    repeat (4 * CPB + 1) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_tx", tx, 1);
    check("abort_count", count, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", ready, 1);
    check("abort_done", done, 0);
    d0 = done_cnt;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (5) @(negedge clk);
      check("post_rst_tx", tx, 1);
    end
    check("abort_no_done", done_cnt - d0, 0);
    mon_en = 1'b1;
    data = 8'h5A; valid = 1'b1; sb.push_back(8'h5A);
    @(negedge clk); valid = 1'b0;
    wait_idle();
    // random bytes, enough pushes to wrap the pointers several times
    for (int i = 0; i < 10; i++) begin
      r = 8'($urandom_range(0, 255));
      check("rand_ready", ready, 1);
      data = r; valid = 1'b1; sb.push_back(r);
      @(negedge clk); valid = 1'b0;
      wait_idle();
    end
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
